// File: rtl/bounded_updown_counter.sv
// Up/down counter confined to a run-time [lo_bound, hi_bound] window with
// wrap, saturate and bounce behaviour at the edges, plus sticky edge flags.
module bounded_updown_counter #(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              dir_i,
  input  logic [1:0]        mode_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_value_i,
  input  logic [WIDTH-1:0]  lo_bound_i,
  input  logic [WIDTH-1:0]  hi_bound_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              clr_flags_i,
  output logic [WIDTH-1:0]  value_o,
  output logic              bound_evt_o,
  output logic              ovf_o,
  output logic              udf_o,
  output logic              bounce_dir_o,
  output logic              at_hi_o,
  output logic              at_lo_o,
  output logic              cfg_err_o
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SAT      = 2'd1,
    MODE_BOUNCE   = 2'd2,
    MODE_WRAP_ALT = 2'd3
  } mode_e;

  logic [WIDTH-1:0] value_q, value_d;
  logic             evt_q, evt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             bdir_q, bdir_d;

  mode_e            mode;
  logic             cfg_err;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   up_raw;
  logic [WIDTH:0]   down_raw;
  logic [WIDTH-1:0] load_clamped;
  logic             going_up;
  logic             hit_hi;
  logic             hit_lo;
  logic             ovf_set;
  logic             udf_set;

  assign mode     = mode_e'(mode_i);
  assign cfg_err  = (lo_bound_i > hi_bound_i);
  assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};

  // One extra bit keeps the raw result exact: up never overflows, and down
  // is read as signed so a step past zero compares below lo_bound.
  assign up_raw   = {1'b0, value_q} + step_ext;
  assign down_raw = {1'b0, value_q} - step_ext;

  assign going_up = (mode == MODE_BOUNCE) ? !bdir_q : !dir_i;
  assign hit_hi   = (mode == MODE_BOUNCE) ? (up_raw >= {1'b0, hi_bound_i})
                                          : (up_raw >  {1'b0, hi_bound_i});
  assign hit_lo   = (mode == MODE_BOUNCE)
                    ? ($signed(down_raw) <= $signed({1'b0, lo_bound_i}))
                    : ($signed(down_raw) <  $signed({1'b0, lo_bound_i}));

  assign load_clamped = (load_value_i < lo_bound_i) ? lo_bound_i :
                        (load_value_i > hi_bound_i) ? hi_bound_i : load_value_i;

  always_comb begin
    value_d = value_q;
    bdir_d  = bdir_q;
    evt_d   = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;

    if (load_i) begin
      value_d = cfg_err ? load_value_i : load_clamped;
    end else if (!cfg_err && en_i && (step_i != '0)) begin
      if (value_q < lo_bound_i) begin
        value_d = lo_bound_i;
      end else if (value_q > hi_bound_i) begin
        value_d = hi_bound_i;
      end else if (going_up) begin
        if (hit_hi) begin
          evt_d   = 1'b1;
          ovf_set = 1'b1;
          case (mode)
            MODE_SAT:    value_d = hi_bound_i;
            MODE_BOUNCE: begin
              value_d = hi_bound_i;
              bdir_d  = 1'b1;
            end
            default:     value_d = lo_bound_i;
          endcase
        end else begin
          value_d = up_raw[WIDTH-1:0];
        end
      end else begin
        if (hit_lo) begin
          evt_d   = 1'b1;
          udf_set = 1'b1;
          case (mode)
            MODE_SAT:    value_d = lo_bound_i;
            MODE_BOUNCE: begin
              value_d = lo_bound_i;
              bdir_d  = 1'b0;
            end
            default:     value_d = hi_bound_i;
          endcase
        end else begin
          value_d = down_raw[WIDTH-1:0];
        end
      end
    end

    // A flag being set in the same cycle as a clear request stays set.
    ovf_d = ovf_set | (ovf_q & !clr_flags_i);
    udf_d = udf_set | (udf_q & !clr_flags_i);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      value_q <= '0;
      evt_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      bdir_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      evt_q   <= evt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      bdir_q  <= bdir_d;
    end
  end

  assign value_o      = value_q;
  assign bound_evt_o  = evt_q;
  assign ovf_o        = ovf_q;
  assign udf_o        = udf_q;
  assign bounce_dir_o = bdir_q;
  assign at_hi_o      = (value_q == hi_bound_i);
  assign at_lo_o      = (value_q == lo_bound_i);
  assign cfg_err_o    = cfg_err;

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Directed bench for bounded_updown_counter at WIDTH=8, STEP_W=4; each task
// drives one scenario and checks against hand-computed values.
module tb_bounded_updown_counter;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       en_i = 1'b0;
  logic       dir_i = 1'b0;
  logic [1:0] mode_i = 2'd0;
  logic       load_i = 1'b0;
  logic [7:0] load_value_i = 8'd0;
  logic [7:0] lo_bound_i = 8'd0;
  logic [7:0] hi_bound_i = 8'd9;
  logic [3:0] step_i = 4'd1;
  logic       clr_flags_i = 1'b0;
  logic [7:0] value_o;
  logic       bound_evt_o, ovf_o, udf_o, bounce_dir_o, at_hi_o, at_lo_o, cfg_err_o;

  int checks = 0;
  int errors = 0;

  bounded_updown_counter #(.WIDTH(8), .STEP_W(4)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .en_i(en_i), .dir_i(dir_i),
    .mode_i(mode_i), .load_i(load_i), .load_value_i(load_value_i),
    .lo_bound_i(lo_bound_i), .hi_bound_i(hi_bound_i), .step_i(step_i),
    .clr_flags_i(clr_flags_i), .value_o(value_o), .bound_evt_o(bound_evt_o),
    .ovf_o(ovf_o), .udf_o(udf_o), .bounce_dir_o(bounce_dir_o),
    .at_hi_o(at_hi_o), .at_lo_o(at_lo_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clock_i = ~clock_i;

  // Inputs change 1ns after the edge and outputs are sampled there too.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; en_i = 1'b1; load_i = 1'b1; load_value_i = 8'd5;
    tick(); tick();
    checks++;
    if ({value_o, bound_evt_o, ovf_o, udf_o, bounce_dir_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got value=%0d evt=%b ovf=%b udf=%b bdir=%b, expected all 0",
               value_o, bound_evt_o, ovf_o, udf_o, bounce_dir_o);
    end
    load_i = 1'b0; en_i = 1'b0; reset_i = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    mode_i = 2'd0; lo_bound_i = 8'd0; hi_bound_i = 8'd9; step_i = 4'd1; dir_i = 1'b0;
    en_i = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (value_o !== 8'(i) || bound_evt_o !== 1'b0) begin
        errors++;
        $display("FAIL wrap_count[%0d]: got value=%0d evt=%b, expected value=%0d evt=0",
                 i, value_o, bound_evt_o, i);
      end
    end
    tick();
    checks++;
    if (value_o !== 8'd0 || bound_evt_o !== 1'b1 || ovf_o !== 1'b1 || at_lo_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap_edge: got value=%0d evt=%b ovf=%b at_lo=%b, expected 0/1/1/1",
               value_o, bound_evt_o, ovf_o, at_lo_o);
    end
    en_i = 1'b0; clr_flags_i = 1'b1;
    tick();
    clr_flags_i = 1'b0;
    checks++;
    if (ovf_o !== 1'b0 || bound_evt_o !== 1'b0) begin
      errors++;
      $display("FAIL wrap_clr: got ovf=%b evt=%b, expected 0/0", ovf_o, bound_evt_o);
    end
  endtask

  task automatic test_saturate();
    mode_i = 2'd1; lo_bound_i = 8'd5; hi_bound_i = 8'd200; step_i = 4'd3;
    load_i = 1'b1; load_value_i = 8'd7;
    tick();
    load_i = 1'b0;
    checks++;
    if (value_o !== 8'd7 || bound_evt_o !== 1'b0 || udf_o !== 1'b0) begin
      errors++;
      $display("FAIL sat_load: got value=%0d evt=%b udf=%b, expected 7/0/0",
               value_o, bound_evt_o, udf_o);
    end
    dir_i = 1'b1; en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (value_o !== 8'd5 || bound_evt_o !== 1'b1 || udf_o !== 1'b1) begin
        errors++;
        $display("FAIL sat_pin[%0d]: got value=%0d evt=%b udf=%b, expected 5/1/1",
                 i, value_o, bound_evt_o, udf_o);
      end
    end
    clr_flags_i = 1'b1;
    tick();
    checks++;
    if (value_o !== 8'd5 || bound_evt_o !== 1'b1 || udf_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_set_wins: got value=%0d evt=%b udf=%b, expected 5/1/1",
               value_o, bound_evt_o, udf_o);
    end
    en_i = 1'b0;
    tick();
    clr_flags_i = 1'b0;
    checks++;
    if (udf_o !== 1'b0 || bound_evt_o !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr: got udf=%b evt=%b, expected 0/0", udf_o, bound_evt_o);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_v [5] = '{8'd4, 8'd6, 8'd4, 8'd2, 8'd4};
    logic       exp_e [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp_b [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    mode_i = 2'd2; lo_bound_i = 8'd2; hi_bound_i = 8'd6; step_i = 4'd2;
    load_i = 1'b1; load_value_i = 8'd2;
    tick();
    load_i = 1'b0; dir_i = 1'b1; en_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (value_o !== exp_v[i] || bound_evt_o !== exp_e[i] || bounce_dir_o !== exp_b[i]) begin
        errors++;
        $display("FAIL bounce[%0d]: got value=%0d evt=%b bdir=%b, expected %0d/%b/%b",
                 i, value_o, bound_evt_o, bounce_dir_o, exp_v[i], exp_e[i], exp_b[i]);
      end
    end
    checks++;
    if (ovf_o !== 1'b1 || udf_o !== 1'b1) begin
      errors++;
      $display("FAIL bounce_flags: got ovf=%b udf=%b, expected 1/1", ovf_o, udf_o);
    end
    en_i = 1'b0; clr_flags_i = 1'b1;
    tick();
    clr_flags_i = 1'b0;
  endtask

  task automatic test_load_clamp();
    mode_i = 2'd0; lo_bound_i = 8'd10; hi_bound_i = 8'd100; step_i = 4'd1; dir_i = 1'b0;
    en_i = 1'b1; load_i = 1'b1; load_value_i = 8'd150;
    tick();
    checks++;
    if (value_o !== 8'd100 || bound_evt_o !== 1'b0 || at_hi_o !== 1'b1) begin
      errors++;
      $display("FAIL clamp_hi: got value=%0d evt=%b at_hi=%b, expected 100/0/1",
               value_o, bound_evt_o, at_hi_o);
    end
    load_value_i = 8'd3;
    tick();
    load_i = 1'b0;
    checks++;
    if (value_o !== 8'd10 || bound_evt_o !== 1'b0) begin
      errors++;
      $display("FAIL clamp_lo: got value=%0d evt=%b, expected 10/0", value_o, bound_evt_o);
    end
    step_i = 4'd0;
    tick();
    checks++;
    if (value_o !== 8'd10 || bound_evt_o !== 1'b0) begin
      errors++;
      $display("FAIL step_zero: got value=%0d evt=%b, expected 10/0", value_o, bound_evt_o);
    end
    // Raise lo_bound above the current value: next enabled cycle snaps to it quietly.
    step_i = 4'd1; lo_bound_i = 8'd20;
    tick();
    checks++;
    if (value_o !== 8'd20 || bound_evt_o !== 1'b0 || udf_o !== 1'b0 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL out_of_range: got value=%0d evt=%b udf=%b ovf=%b, expected 20/0/0/0",
               value_o, bound_evt_o, udf_o, ovf_o);
    end
    en_i = 1'b0;
  endtask

  task automatic test_cfg_err();
    lo_bound_i = 8'd10; hi_bound_i = 8'd5; en_i = 1'b1; step_i = 4'd1;
    #1;
    checks++;
    if (cfg_err_o !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_flag: got %b expected 1", cfg_err_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (value_o !== 8'd20 || bound_evt_o !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_hold[%0d]: got value=%0d evt=%b, expected 20/0",
                 i, value_o, bound_evt_o);
      end
    end
    load_i = 1'b1; load_value_i = 8'd3;
    tick();
    load_i = 1'b0;
    checks++;
    if (value_o !== 8'd3) begin
      errors++;
      $display("FAIL cfg_err_load: got value=%0d expected 3 (unclamped)", value_o);
    end
    en_i = 1'b0;
  endtask

  task automatic test_midop_reset();
    mode_i = 2'd2; lo_bound_i = 8'd0; hi_bound_i = 8'd60; step_i = 4'd5;
    load_i = 1'b1; load_value_i = 8'd58;
    tick();
    load_i = 1'b0; en_i = 1'b1;
    tick();
    checks++;
    if (value_o !== 8'd60 || ovf_o !== 1'b1 || bounce_dir_o !== 1'b1) begin
      errors++;
      $display("FAIL midop_setup: got value=%0d ovf=%b bdir=%b, expected 60/1/1",
               value_o, ovf_o, bounce_dir_o);
    end
    mode_i = 2'd0; load_i = 1'b1; load_value_i = 8'd57;
    tick();
    load_i = 1'b0;
    checks++;
    if (value_o !== 8'd57 || ovf_o !== 1'b1 || bounce_dir_o !== 1'b1) begin
      errors++;
      $display("FAIL midop_load: got value=%0d ovf=%b bdir=%b, expected 57/1/1",
               value_o, ovf_o, bounce_dir_o);
    end
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1; en_i = 1'b0;
    checks++;
    if (value_o !== 8'd0 || ovf_o !== 1'b0 || udf_o !== 1'b0 || bounce_dir_o !== 1'b0
        || bound_evt_o !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: got value=%0d ovf=%b udf=%b bdir=%b evt=%b, expected all 0",
               value_o, ovf_o, udf_o, bounce_dir_o, bound_evt_o);
    end
  endtask

  task automatic test_back_to_back();
    // Mode 3 behaves as wrap; then a down-wrap from lo in the same run.
    mode_i = 2'd3; lo_bound_i = 8'd0; hi_bound_i = 8'd3; step_i = 4'd1; dir_i = 1'b0;
    load_i = 1'b1; load_value_i = 8'd3;
    tick();
    load_i = 1'b0; en_i = 1'b1;
    tick();
    checks++;
    if (value_o !== 8'd0 || bound_evt_o !== 1'b1 || ovf_o !== 1'b1) begin
      errors++;
      $display("FAIL mode3_wrap: got value=%0d evt=%b ovf=%b, expected 0/1/1",
               value_o, bound_evt_o, ovf_o);
    end
    dir_i = 1'b1; step_i = 4'd2;
    tick();
    checks++;
    if (value_o !== 8'd3 || bound_evt_o !== 1'b1 || udf_o !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: got value=%0d evt=%b udf=%b, expected 3/1/1",
               value_o, bound_evt_o, udf_o);
    end
    tick();
    checks++;
    if (value_o !== 8'd1 || bound_evt_o !== 1'b0) begin
      errors++;
      $display("FAIL down_step: got value=%0d evt=%b, expected 1/0", value_o, bound_evt_o);
    end
    en_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_bounce();
    test_load_clamp();
    test_cfg_err();
    test_midop_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
